// File: rtl/bist_sequencer.sv
// ============================================================================
// Module   : bist_sequencer
// Purpose  : Walks built-in self-test across NUM_PORTS router ports, one port
//            at a time. Every bist pair is held in reset except the one under
//            test. Per-port fail/timeout vectors and a global pass flag are
//            accumulated for the test-mode top level.
//            Optional macro BIST_SEQ_RETRY_EN: a failing port is retried once
//            and only the retry's outcome is recorded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_sequencer #(
    parameter int  NUM_PORTS      = 5,
    parameter int  RESET_CYCLES   = 4,
    parameter int  TIMEOUT_CYCLES = 2000,
    localparam int c_port_w       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_PORTS-1:0] port_mask,
    input  logic [NUM_PORTS-1:0] bist_busy,
    input  logic [NUM_PORTS-1:0] bist_sig_ok,
    output logic [NUM_PORTS-1:0] bist_reset,
    output logic [c_port_w-1:0]  cur_port,
    output logic                 active,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_PORTS-1:0] fail_vec,
    output logic [NUM_PORTS-1:0] timeout_vec
);

    // Search index is one bit wider so cur_port+1 == NUM_PORTS cannot wrap.
    localparam int c_idx_w = c_port_w + 1;
    localparam int c_run_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int c_rst_w = $clog2(RESET_CYCLES) + 1;
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEEK  = 3'd1,
        S_RST   = 3'd2,
        S_RUN   = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    logic [NUM_PORTS-1:0] r_mask;
    logic [NUM_PORTS-1:0] r_bist_reset;
    logic [NUM_PORTS-1:0] r_fail;
    logic [NUM_PORTS-1:0] r_timeout;
    logic [c_port_w-1:0]  r_cur_port;
    logic [c_idx_w-1:0]   r_search_idx;
    logic [c_run_w-1:0]   r_run_cnt;
    logic [c_rst_w-1:0]   r_rst_cnt;
    logic                 r_active;
    logic                 r_done;
    logic                 r_pass;

    logic [NUM_PORTS-1:0] w_cur_onehot;
    logic                 w_busy_cur;
    logic                 w_sig_cur;
    logic [c_idx_w-1:0]   w_idx_next;
    logic                 w_found;
    logic [c_port_w-1:0]  w_next_port;
    logic                 w_can_retry;

`ifdef BIST_SEQ_RETRY_EN
    logic                 r_retry;
    assign w_can_retry = ~r_retry;
`else
    assign w_can_retry = 1'b0;
`endif

    assign w_cur_onehot = NUM_PORTS'(1) << r_cur_port;
    assign w_busy_cur   = |(bist_busy & w_cur_onehot);
    assign w_sig_cur    = |(bist_sig_ok & w_cur_onehot);
    assign w_idx_next   = {1'b0, r_cur_port} + c_idx_w'(1);

    // Lowest enabled port at or above the search index (descending scan so the lowest wins).
    always_comb begin
        w_found     = 1'b0;
        w_next_port = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (r_mask[i] && (c_idx_w'(i) >= r_search_idx)) begin
                w_found     = 1'b1;
                w_next_port = c_port_w'(i);
            end
        end
    end

    // Sequencer FSM with registered outputs; bist_reset is released only for the RUN window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_bist_reset <= '1;
            r_fail       <= '0;
            r_timeout    <= '0;
            r_cur_port   <= '0;
            r_search_idx <= '0;
            r_run_cnt    <= '0;
            r_rst_cnt    <= '0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
`ifdef BIST_SEQ_RETRY_EN
            r_retry      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mask       <= port_mask;
                        r_fail       <= '0;
                        r_timeout    <= '0;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_active     <= 1'b1;
                        r_search_idx <= '0;
                        r_state      <= S_SEEK;
`ifdef BIST_SEQ_RETRY_EN
                        r_retry      <= 1'b0;
`endif
                    end
                end
                S_SEEK: begin
                    if (w_found) begin
                        r_cur_port <= w_next_port;
                        r_rst_cnt  <= '0;
                        r_state    <= S_RST;
                    end else begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= ~|r_fail;
                        r_state  <= S_DONE;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == c_rst_last) begin
                        r_rst_cnt    <= '0;
                        r_run_cnt    <= '0;
                        r_bist_reset <= ~w_cur_onehot;
                        r_state      <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + c_rst_w'(1);
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + c_run_w'(1);
                    // First RUN cycle ignores busy to absorb sender reset-release latency.
                    if ((r_run_cnt != '0) && !w_busy_cur) begin
                        r_bist_reset <= '1;
                        r_state      <= S_CHECK;
                    end else if (r_run_cnt == c_run_last) begin
                        r_bist_reset <= '1;
                        if (w_can_retry) begin
                            r_rst_cnt <= '0;
                            r_state   <= S_RST;
`ifdef BIST_SEQ_RETRY_EN
                            r_retry   <= 1'b1;
`endif
                        end else begin
                            r_fail       <= r_fail | w_cur_onehot;
                            r_timeout    <= r_timeout | w_cur_onehot;
                            r_search_idx <= w_idx_next;
                            r_state      <= S_SEEK;
`ifdef BIST_SEQ_RETRY_EN
                            r_retry      <= 1'b0;
`endif
                        end
                    end
                end
                S_CHECK: begin
                    if (!w_sig_cur && w_can_retry) begin
                        r_rst_cnt <= '0;
                        r_state   <= S_RST;
`ifdef BIST_SEQ_RETRY_EN
                        r_retry   <= 1'b1;
`endif
                    end else begin
                        if (!w_sig_cur) begin
                            r_fail <= r_fail | w_cur_onehot;
                        end
                        r_search_idx <= w_idx_next;
                        r_state      <= S_SEEK;
`ifdef BIST_SEQ_RETRY_EN
                        r_retry      <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bist_reset  = r_bist_reset;
    assign cur_port    = r_cur_port;
    assign active      = r_active;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_vec    = r_fail;
    assign timeout_vec = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bist_sequencer.sv
// ============================================================================
// Module   : tb_bist_sequencer
// Purpose  : Self-checking bench for bist_sequencer. A reactive BIST-pair
//            model drives busy/sig_ok from each port's reset window; expected
//            windows, vectors and completion time come from a per-port
//            outcome model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bist_sequencer;

    localparam int NP    = 5;
    localparam int RC    = 4;
    localparam int TO    = 2000;
    localparam int STUCK = 1 << 30;
`ifdef BIST_SEQ_RETRY_EN
    localparam int MAX_ATT = 1;
`else
    localparam int MAX_ATT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NP-1:0] port_mask;
    logic [NP-1:0] bist_busy;
    logic [NP-1:0] bist_sig_ok;
    logic [NP-1:0] bist_reset;
    logic [2:0]    cur_port;
    logic          active;
    logic          done;
    logic          pass;
    logic [NP-1:0] fail_vec;
    logic [NP-1:0] timeout_vec;

    bist_sequencer #(
        .NUM_PORTS      (NP),
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .port_mask   (port_mask),
        .bist_busy   (bist_busy),
        .bist_sig_ok (bist_sig_ok),
        .bist_reset  (bist_reset),
        .cur_port    (cur_port),
        .active      (active),
        .done        (done),
        .pass        (pass),
        .fail_vec    (fail_vec),
        .timeout_vec (timeout_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int port;
        int len;
    } win_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   lat [NP][2];
    bit   sig [NP][2];
    int   kk [NP];
    int   att [NP];
    int   wcount [NP];
    int   bad_multi;
    int   bad_cur;
    win_t wins[$];
    win_t exp_wins[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reactive BIST pair model: busy rises one cycle after release and falls lat cycles after release.
    initial begin
        bist_busy   = '0;
        bist_sig_ok = NP'($urandom);
        for (int p = 0; p < NP; p++) kk[p] = 0;
        forever begin
            @(negedge clk);
            if ($countones(~bist_reset) > 1) bad_multi++;
            for (int p = 0; p < NP; p++) begin
                if (!bist_reset[p]) begin
                    if (kk[p] == 0) begin
                        att[p] = (wcount[p] > 0) ? 1 : 0;
                        wcount[p]++;
                        bist_sig_ok[p] = sig[p][att[p]];
                    end
                    kk[p]++;
                    if (cur_port != 3'(p)) bad_cur++;
                    bist_busy[p] = (kk[p] >= 2) && (kk[p] <= lat[p][att[p]]);
                end else begin
                    if (kk[p] > 0) wins.push_back('{port: p, len: kk[p]});
                    kk[p]        = 0;
                    bist_busy[p] = 1'b0;
                end
            end
        end
    end

    // Outcome model: per enabled port, a run lasts lat+1 cycles or TO cycles when busy never falls in time.
    task automatic build_expect(input logic [NP-1:0] m, output int cyc_o,
                                output logic [NP-1:0] f_o, output logic [NP-1:0] t_o);
        int r;
        bit to;
        bit bad;
        cyc_o = 1;
        f_o   = '0;
        t_o   = '0;
        exp_wins.delete();
        for (int p = 0; p < NP; p++) begin
            if (m[p]) begin
                cyc_o += 1;
                for (int a = 0; a <= MAX_ATT; a++) begin
                    to  = (lat[p][a] >= TO);
                    r   = to ? TO : lat[p][a] + 1;
                    bad = to || !sig[p][a];
                    cyc_o += RC + r + (to ? 0 : 1);
                    exp_wins.push_back('{port: p, len: r});
                    if (!bad || a == MAX_ATT) begin
                        f_o[p] = bad;
                        t_o[p] = to;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic prep();
        @(posedge clk);
        #1;
        wins.delete();
        for (int p = 0; p < NP; p++) wcount[p] = 0;
        bad_multi = 0;
        bad_cur   = 0;
    endtask

    task automatic set_all(input int l, input bit s);
        for (int p = 0; p < NP; p++) begin
            lat[p][0] = l; lat[p][1] = l;
            sig[p][0] = s; sig[p][1] = s;
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return STUCK;
        if (r == 1) return TO - 1;
        return $urandom_range(1, 60);
    endfunction

    task automatic run_seq(input string name, input logic [NP-1:0] m, input bit mid_start);
        int            exp_cyc;
        logic [NP-1:0] ef;
        logic [NP-1:0] et;
        int            c0;
        int            n;
        build_expect(m, exp_cyc, ef, et);
        prep();
        @(negedge clk);
        port_mask = m;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        port_mask = NP'($urandom);
        c0        = cyc;
        check_eq({name, ":active"}, 32'(active), 32'd1);
        while (!done && (cyc - c0) < exp_cyc + 100) begin
            @(negedge clk);
            if (mid_start && (cyc - c0) == 6) begin
                start     = 1'b1;
                port_mask = '0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq({name, ":done_time"}, 32'(cyc - c0), 32'(exp_cyc));
        check_eq({name, ":fail_vec"}, 32'(fail_vec), 32'(ef));
        check_eq({name, ":timeout_vec"}, 32'(timeout_vec), 32'(et));
        check_eq({name, ":pass"}, 32'(pass), 32'(ef == '0));
        check_eq({name, ":active_end"}, 32'(active), 32'd0);
        check_eq({name, ":win_count"}, 32'(wins.size()), 32'(exp_wins.size()));
        n = (wins.size() < exp_wins.size()) ? wins.size() : exp_wins.size();
        for (int i = 0; i < n; i++) begin
            check_eq({name, ":win_port"}, 32'(wins[i].port), 32'(exp_wins[i].port));
            check_eq({name, ":win_len"}, 32'(wins[i].len), 32'(exp_wins[i].len));
        end
        check_eq({name, ":one_window"}, 32'(bad_multi), 32'd0);
        check_eq({name, ":cur_port"}, 32'(bad_cur), 32'd0);
        repeat (3) @(negedge clk);
        check_eq({name, ":done_hold"}, 32'(done), 32'd1);
        check_eq({name, ":rst_idle"}, 32'(bist_reset), 32'h1f);
    endtask

    task automatic check_reset_vals(input string name);
        check_eq({name, ":bist_reset"}, 32'(bist_reset), 32'h1f);
        check_eq({name, ":cur_port"}, 32'(cur_port), 32'd0);
        check_eq({name, ":active"}, 32'(active), 32'd0);
        check_eq({name, ":done"}, 32'(done), 32'd0);
        check_eq({name, ":pass"}, 32'(pass), 32'd0);
        check_eq({name, ":fail_vec"}, 32'(fail_vec), 32'd0);
        check_eq({name, ":timeout_vec"}, 32'(timeout_vec), 32'd0);
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        start     = 1'b0;
        port_mask = '0;
        set_all(10, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // All ports, long busy, all pass.
        set_all(1000, 1'b1);
        run_seq("all_pass", 5'b11111, 1'b0);

        // Single port with signature mismatch.
        set_all(30, 1'b1);
        sig[2][0] = 1'b0; sig[2][1] = 1'b0;
        run_seq("sig_fail", 5'b00100, 1'b0);

        // Port 3 stuck busy; a start pulsed during RUN must be ignored.
        set_all(20, 1'b1);
        lat[3][0] = STUCK; lat[3][1] = STUCK;
        run_seq("timeout", 5'b11111, 1'b1);

        // Busy falling on the last permitted cycle is completion.
        set_all(TO - 1, 1'b1);
        run_seq("edge_done", 5'b00010, 1'b0);

        // Empty mask.
        run_seq("empty", 5'b00000, 1'b0);

        // Reset in RUN of port 1 aborts everything.
        set_all(50, 1'b1);
        sig[0][0] = 1'b0; sig[0][1] = 1'b0;
        prep();
        @(negedge clk);
        port_mask = 5'b11111;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (!bist_reset[1]) found = 1'b1;
        end
        check_eq("abort:reach_port1", 32'(found), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("abort:pre_fail", 32'(fail_vec), 32'h01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("abort");
        set_all(15, 1'b1);
        run_seq("restart", 5'b11111, 1'b0);

        // Retry behaviour on port 0 (first outcome final when retry is not built in).
        set_all(25, 1'b1);
        sig[0][0] = 1'b0;
        run_seq("retry_pass", 5'b00001, 1'b0);
        sig[0][0] = 1'b0; sig[0][1] = 1'b0;
        run_seq("retry_fail", 5'b00001, 1'b0);

        // Randomized sequences.
        for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < NP; p++) begin
                for (int a = 0; a < 2; a++) begin
                    lat[p][a] = pick_lat();
                    sig[p][a] = ($urandom_range(0, 3) != 0);
                end
            end
            run_seq("random", NP'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
